commit_buffer: RTL

COMMIT_BUFFER -- requirements
Module: commit_buffer

---
 rtl/commit_buffer_pkg.sv | 36 +++
 rtl/commit_buffer_fwd.sv | 38 +++
 rtl/commit_buffer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : commit_buffer_pkg
//  Description : Shared constants for the commit buffer: entry type codes,
//                store width codes, store FSM state type and a helper that
//                maps an entry's dest field to a store width.
//  Revision    : 1.0 - initial release
// ============================================================================
package commit_buffer_pkg;

    // Entry type codes carried on alloc_type_in
    localparam logic [1:0] C_TYPE_REG    = 2'b00;
    localparam logic [1:0] C_TYPE_BRANCH = 2'b01;
    localparam logic [1:0] C_TYPE_STORE  = 2'b10;

    // Store width codes carried in dest[1:0] of a STORE entry
    localparam logic [1:0] C_WIDTH_B = 2'b00;
    localparam logic [1:0] C_WIDTH_H = 2'b01;
    localparam logic [1:0] C_WIDTH_W = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } st_state_t;

    // The unused code 2'b11 is treated as a word store
    function automatic logic [1:0] f_store_width(input logic [4:0] dest);
        case (dest[1:0])
            C_WIDTH_B: f_store_width = C_WIDTH_B;
            C_WIDTH_H: f_store_width = C_WIDTH_H;
            default:   f_store_width = C_WIDTH_W;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/commit_buffer_fwd.sv
`default_nettype none
// ============================================================================
//  Module      : commit_buffer_fwd
//  Description : One operand lookup into the commit buffer with same-cycle
//                writeback bypass. The highest-numbered matching port wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_buffer_fwd
    import commit_buffer_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int WB_PORTS = 3,
    parameter int TW       = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         i_ready,
    input  logic [DEPTH-1:0][31:0]   i_value,
    input  logic [TW-1:0]            i_tag,
    input  logic [WB_PORTS-1:0]      i_wb_en,
    input  logic [WB_PORTS*TW-1:0]   i_wb_tag,
    input  logic [WB_PORTS*32-1:0]   i_wb_value,
    output logic                     o_ready,
    output logic [31:0]              o_value
);

    // Stored entry first, then each matching writeback port overrides in order
    always_comb begin
        o_ready = i_ready[i_tag];
        o_value = i_value[i_tag];
        for (int p = 0; p < WB_PORTS; p++) begin
            if (i_wb_en[p] && (i_wb_tag[p*TW +: TW] == i_tag)) begin
                o_ready = 1'b1;
                o_value = i_wb_value[p*32 +: 32];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/commit_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : commit_buffer
//  Description : In-order commit buffer. Allocates at the tail, collects
//                writebacks, retires up to COMMIT_W register results per
//                cycle, commits branches (predictor update / flush) and hands
//                stores to memory through a request/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_buffer
    import commit_buffer_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int WB_PORTS = 3,
    parameter int COMMIT_W = 2,
    parameter int TW       = $clog2(DEPTH)
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     alloc_en_in,
    input  logic [1:0]               alloc_type_in,
    input  logic [4:0]               alloc_dest_in,
    input  logic [31:0]              alloc_pc_in,
    input  logic [31:0]              alloc_target_in,
    input  logic                     alloc_taken_in,
    output logic [TW-1:0]            alloc_tag_out,
    output logic                     full_out,
    output logic [TW:0]              count_out,
    input  logic [WB_PORTS-1:0]      wb_en_in,
    input  logic [WB_PORTS*TW-1:0]   wb_tag_in,
    input  logic [WB_PORTS*32-1:0]   wb_value_in,
    input  logic                     sa_en_in,
    input  logic [TW-1:0]            sa_tag_in,
    input  logic [31:0]              sa_addr_in,
    input  logic [2*TW-1:0]          q_tag_in,
    output logic [1:0]               q_ready_out,
    output logic [63:0]              q_value_out,
    output logic [COMMIT_W-1:0]      cm_en_out,
    output logic [5*COMMIT_W-1:0]    cm_dest_out,
    output logic [32*COMMIT_W-1:0]   cm_value_out,
    output logic [TW*COMMIT_W-1:0]   cm_tag_out,
    output logic                     st_req_out,
    output logic [31:0]              st_addr_out,
    output logic [31:0]              st_data_out,
    output logic [1:0]               st_width_out,
    input  logic                     st_ack_in,
    output logic                     bp_en_out,
    output logic                     bp_correct_out,
    output logic [31:0]              bp_pc_out,
    output logic                     flush_out,
    output logic [31:0]              flush_pc_out
);

    logic [TW-1:0]                r_head, r_tail;
    logic [TW:0]                  r_count;
    logic [DEPTH-1:0]             r_valid, r_ready, r_addr_valid, r_taken;
    logic [DEPTH-1:0][1:0]        r_type;
    logic [DEPTH-1:0][4:0]        r_dest;
    logic [DEPTH-1:0][31:0]       r_pc, r_target, r_value, r_addr;
    st_state_t                    r_state, w_state_next;

    logic [COMMIT_W-1:0][TW-1:0]  w_slot_idx;
    logic [COMMIT_W-1:0]          w_cm_en;
    logic [TW:0]                  w_retire;
    logic                         w_chain, w_actual_taken;
    logic                         w_bp_en, w_bp_correct, w_flush, w_st_start;
    logic [31:0]                  w_flush_pc;
    logic                         w_full, w_alloc_ok;
    logic [1:0]                   w_q_ready;
    logic [63:0]                  w_q_value;

    assign w_full        = (r_count == (TW+1)'(DEPTH));
    assign full_out      = w_full;
    assign count_out     = r_count;
    assign alloc_tag_out = r_tail;
    assign st_req_out    = (r_state == ST_WAIT);
    // Full is judged on the pre-commit count; a flushing cycle drops allocs
    assign w_alloc_ok    = alloc_en_in & ~w_full & rdy_in & ~w_flush;

    for (genvar k = 0; k < COMMIT_W; k++) begin : g_slot
        assign w_slot_idx[k] = r_head + TW'(k);
    end

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        commit_buffer_fwd #(
            .DEPTH    (DEPTH),
            .WB_PORTS (WB_PORTS),
            .TW       (TW)
        ) u_fwd (
            .i_ready    (r_ready),
            .i_value    (r_value),
            .i_tag      (q_tag_in[g*TW +: TW]),
            .i_wb_en    (wb_en_in),
            .i_wb_tag   (wb_tag_in),
            .i_wb_value (wb_value_in),
            .o_ready    (w_q_ready[g]),
            .o_value    (w_q_value[g*32 +: 32])
        );
    end

    // Lookup results are forced low while reset is held
    assign q_ready_out = w_q_ready & {2{rst_n_in}};
    assign q_value_out = w_q_value & {64{rst_n_in}};

    // Commit decision and store FSM next state
    always_comb begin
        w_state_next   = r_state;
        w_cm_en        = '0;
        w_retire       = '0;
        w_chain        = 1'b0;
        w_bp_en        = 1'b0;
        w_bp_correct   = 1'b0;
        w_flush        = 1'b0;
        w_flush_pc     = '0;
        w_st_start     = 1'b0;
        w_actual_taken = r_value[r_head][0];
        if (rdy_in) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_valid[r_head] && r_ready[r_head]) begin
                        if (r_type[r_head] == C_TYPE_REG) begin
                            w_cm_en[0] = 1'b1;
                            w_retire   = (TW+1)'(1);
                            w_chain    = 1'b1;
                            for (int k = 1; k < COMMIT_W; k++) begin
                                if (w_chain && r_valid[w_slot_idx[k]] && r_ready[w_slot_idx[k]]
                                    && (r_type[w_slot_idx[k]] == C_TYPE_REG)) begin
                                    w_cm_en[k] = 1'b1;
                                    w_retire   = w_retire + (TW+1)'(1);
                                end else begin
                                    w_chain = 1'b0;
                                end
                            end
                        end else if (r_type[r_head] == C_TYPE_BRANCH) begin
                            w_bp_en  = 1'b1;
                            w_retire = (TW+1)'(1);
                            if (w_actual_taken == r_taken[r_head]) begin
                                w_bp_correct = 1'b1;
                            end else begin
                                w_flush    = 1'b1;
                                w_flush_pc = w_actual_taken ? r_target[r_head] : (r_pc[r_head] + 32'd4);
                            end
                        end else if ((r_type[r_head] == C_TYPE_STORE) && r_addr_valid[r_head]) begin
                            w_state_next = ST_WAIT;
                            w_st_start   = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (st_ack_in) begin
                        w_retire     = (TW+1)'(1);
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Store FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
        end else if (w_flush) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Entry array, pointers and occupancy
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_valid      <= '0;
            r_ready      <= '0;
            r_addr_valid <= '0;
            r_taken      <= '0;
            r_type       <= '0;
            r_dest       <= '0;
            r_pc         <= '0;
            r_target     <= '0;
            r_value      <= '0;
            r_addr       <= '0;
        end else if (rdy_in) begin
            if (w_flush) begin
                r_head       <= '0;
                r_tail       <= '0;
                r_count      <= '0;
                r_valid      <= '0;
                r_ready      <= '0;
                r_addr_valid <= '0;
            end else begin
                // Later ports overwrite earlier ones on a shared tag
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_en_in[p]) begin
                        r_value[wb_tag_in[p*TW +: TW]] <= wb_value_in[p*32 +: 32];
                        r_ready[wb_tag_in[p*TW +: TW]] <= 1'b1;
                    end
                end
                if (sa_en_in) begin
                    r_addr[sa_tag_in]       <= sa_addr_in;
                    r_addr_valid[sa_tag_in] <= 1'b1;
                end
                for (int k = 0; k < COMMIT_W; k++) begin
                    if ((TW+1)'(k) < w_retire) begin
                        r_valid[w_slot_idx[k]] <= 1'b0;
                    end
                end
                if (w_alloc_ok) begin
                    r_valid[r_tail]      <= 1'b1;
                    r_ready[r_tail]      <= 1'b0;
                    r_addr_valid[r_tail] <= 1'b0;
                    r_type[r_tail]       <= alloc_type_in;
                    r_dest[r_tail]       <= alloc_dest_in;
                    r_pc[r_tail]         <= alloc_pc_in;
                    r_target[r_tail]     <= alloc_target_in;
                    r_taken[r_tail]      <= alloc_taken_in;
                    r_tail               <= r_tail + TW'(1);
                end
                r_head  <= r_head + w_retire[TW-1:0];
                r_count <= r_count + (TW+1)'(w_alloc_ok) - w_retire;
            end
        end
    end

    // Registered commit pulses, predictor update and redirect
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cm_en_out      <= '0;
            cm_dest_out    <= '0;
            cm_value_out   <= '0;
            cm_tag_out     <= '0;
            bp_en_out      <= 1'b0;
            bp_correct_out <= 1'b0;
            bp_pc_out      <= '0;
            flush_out      <= 1'b0;
            flush_pc_out   <= '0;
        end else begin
            cm_en_out      <= w_cm_en;
            bp_en_out      <= w_bp_en;
            bp_correct_out <= w_bp_correct;
            bp_pc_out      <= w_bp_en ? r_pc[r_head] : 32'd0;
            flush_out      <= w_flush;
            flush_pc_out   <= w_flush_pc;
            for (int k = 0; k < COMMIT_W; k++) begin
                cm_dest_out[k*5 +: 5]    <= r_dest[w_slot_idx[k]];
                cm_value_out[k*32 +: 32] <= r_value[w_slot_idx[k]];
                cm_tag_out[k*TW +: TW]   <= w_slot_idx[k];
            end
        end
    end

    // Store request payload, captured once when the FSM enters WAIT
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            st_addr_out  <= '0;
            st_data_out  <= '0;
            st_width_out <= '0;
        end else if (w_st_start) begin
            st_addr_out  <= r_addr[r_head];
            st_data_out  <= r_value[r_head];
            st_width_out <= f_store_width(r_dest[r_head]);
        end
    end

endmodule
`default_nettype wire
